ballot_unit: RTL and testbench

- Voter-facing front end that sits directly upstream of the vote-counting EVM core.
- Conditions four raw candidate push-buttons and enforces one ballot per officer authorisation.
- Emits the candidate[1:0] code plus a single-cycle vote strobe that the counter stage consumes.
- Rejects bounce, held buttons, multi-button presses and abandoned ballots (timeout).

---
 rtl/ballot_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/ballot_unit.sv | 97 +++++++++
 tb/tb_ballot_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ballot_pkg.sv
// Shared types and helpers for the ballot front end.
// Holds the FSM state encoding, button count and candidate code width.
package ballot_pkg;

    localparam int NUM_BTN = 4;
    localparam int CAND_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAST,
        WAIT_REL
    } state_t;

    // The highest set bit wins. The FSM only calls this when exactly one bit is set.
    function automatic logic [CAND_W-1:0] btn_index(input logic [NUM_BTN-1:0] v);
        btn_index = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (v[i]) btn_index = CAND_W'(i);
        end
    endfunction

    function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
        return (v != '0) && ((v & (v - NUM_BTN'(1))) == '0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button conditioning: a 2-flop synchroniser feeds a debounce counter. The module emits the debounced level and a rise pulse.
// Latency: the level follows a stable raw input after 2 + DEBOUNCE_CYCLES cycles. There is no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            // Any sample that agrees with the current level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/ballot_unit.sv
// Voter front end: debounces four buttons and allows one vote per officer authorisation.
// vote is strobed one cycle after a single debounced press while armed. Multi-button presses and abandoned ballots are rejected.
import ballot_pkg::*;

module ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int CAST_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ballot_issue,
    input  logic [NUM_BTN-1:0]    btn,
    output logic [CAND_W-1:0]     candidate,
    output logic                  vote,
    output logic                  ready,
    output logic                  invalid,
    output logic                  timeout,
    output logic [CAST_CNT_W-1:0] ballots_cast
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_BTN-1:0] levels;
    logic [NUM_BTN-1:0] rises;
    logic [TCNT_W-1:0]  tcnt;
    state_t             state;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (btn[i]),
            .level (levels[i]),
            .rise  (rises[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tcnt         <= '0;
            candidate    <= '0;
            vote         <= 1'b0;
            ready        <= 1'b0;
            invalid      <= 1'b0;
            timeout      <= 1'b0;
            ballots_cast <= '0;
        end else begin
            vote    <= 1'b0;
            invalid <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (ballot_issue) begin
                        state <= ARMED;
                        ready <= 1'b1;
                    end
                end
                ARMED: begin
                    // A valid press takes priority over an expiring timer.
                    if (is_onehot(rises)) begin
                        state     <= CAST;
                        ready     <= 1'b0;
                        vote      <= 1'b1;
                        candidate <= btn_index(rises);
                        if (ballots_cast != '1) begin
                            ballots_cast <= ballots_cast + CAST_CNT_W'(1);
                        end
                    end else begin
                        if (rises != '0) invalid <= 1'b1;
                        if (tcnt == TCNT_MAX) begin
                            state   <= IDLE;
                            ready   <= 1'b0;
                            timeout <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                CAST: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (levels == '0) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_unit.sv
// Self-checking bench for ballot_unit, using DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
// Expected candidates are queued when a press is driven and popped when vote is seen.
module tb_ballot_unit;

    localparam int D = 4;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       ballot_issue;
    logic [3:0] btn;
    logic [1:0] candidate;
    logic       vote;
    logic       ready;
    logic       invalid;
    logic       timeout;
    logic [7:0] ballots_cast;

    ballot_unit #(
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (T),
        .CAST_CNT_W      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ballot_issue (ballot_issue),
        .btn          (btn),
        .candidate    (candidate),
        .vote         (vote),
        .ready        (ready),
        .invalid      (invalid),
        .timeout      (timeout),
        .ballots_cast (ballots_cast)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_vote = 0;
    int         n_inv = 0;
    int         n_to = 0;
    int         last_vote_cyc = -100;
    logic       prev_vote = 1'b0;
    logic [1:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (vote) begin
                n_vote++;
                last_vote_cyc = cyc;
                check("vote_single_cycle", 32'(prev_vote), 0);
                check("vote_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) check("vote_candidate", 32'(candidate), 32'(sb.pop_front()));
            end
            if (invalid) n_inv++;
            if (timeout) n_to++;
        end
        prev_vote = vote;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue();
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
    endtask

    task automatic glitch(input logic [3:0] p);
        repeat (3) begin
            btn = p;
            tick(1);
            btn = 4'b0;
            tick(1);
        end
    endtask

    typedef struct {
        bit         do_issue;
        bit         bounce;
        logic [3:0] pat;
        int         votes;
        int         invs;
        logic [1:0] cand;
    } vec_t;

    vec_t tbl[5];
    int   exp_cast = 0;
    int   v0, i0, t0, pc;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 4'b0010, 1, 0, 2'd1};
        tbl[1] = '{1'b0, 1'b0, 4'b1000, 0, 0, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 4'b1001, 0, 1, 2'd0};
        tbl[3] = '{1'b0, 1'b0, 4'b1000, 1, 0, 2'd3};
        tbl[4] = '{1'b0, 1'b0, 4'b0001, 0, 0, 2'd0};

        reset = 1'b1;
        ballot_issue = 1'b0;
        btn = 4'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_candidate", 32'(candidate), 0);
        check("rst_vote", 32'(vote), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_invalid", 32'(invalid), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_cast", 32'(ballots_cast), 0);

        // Clean press on btn[2]: vote lands 2 + D + 1 cycles after the raw press.
        issue();
        check("armed_ready", 32'(ready), 1);
        sb.push_back(2'd2);
        btn = 4'b0100;
        pc = cyc;
        tick(20);
        check("vote_latency", 32'(last_vote_cyc - pc), 7);
        exp_cast = 1;
        check("cast_after_first", 32'(ballots_cast), 1);
        check("ready_wait_rel", 32'(ready), 0);
        btn = 4'b0;
        tick(12);

        for (int i = 0; i < 5; i++) begin
            v0 = n_vote;
            i0 = n_inv;
            if (tbl[i].bounce) glitch(tbl[i].pat);
            if (tbl[i].do_issue) begin
                issue();
                check($sformatf("vec%0d_ready", i), 32'(ready), 1);
            end
            if (tbl[i].bounce) glitch(tbl[i].pat);
            if (tbl[i].votes > 0) sb.push_back(tbl[i].cand);
            btn = tbl[i].pat;
            tick(20);
            btn = 4'b0;
            tick(12);
            exp_cast += tbl[i].votes;
            check($sformatf("vec%0d_votes", i), 32'(n_vote - v0), 32'(tbl[i].votes));
            check($sformatf("vec%0d_invalid", i), 32'(n_inv - i0), 32'(tbl[i].invs));
            check($sformatf("vec%0d_cast", i), 32'(ballots_cast), 32'(exp_cast));
        end

        // Abandoned ballot: ARMED lasts exactly T cycles, then a single timeout pulse.
        v0 = n_vote;
        t0 = n_to;
        issue();
        tick(T - 1);
        check("to_still_armed", 32'(ready), 1);
        tick(1);
        check("to_ready_low", 32'(ready), 0);
        check("to_pulse", 32'(timeout), 1);
        tick(1);
        check("to_pulse_end", 32'(timeout), 0);
        btn = 4'b0001;
        tick(20);
        btn = 4'b0;
        tick(12);
        check("to_count", 32'(n_to - t0), 1);
        check("to_no_vote", 32'(n_vote - v0), 0);
        check("to_cast", 32'(ballots_cast), 32'(exp_cast));

        // Reset while ARMED.
        issue();
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("rstA_ready", 32'(ready), 0);
        check("rstA_cast", 32'(ballots_cast), 0);
        tick(1);
        reset = 1'b0;
        sb.delete();
        tick(2);
        check("rstA_idle", 32'(ready), 0);

        // Reset while WAIT_REL, with the button still held.
        issue();
        sb.push_back(2'd0);
        btn = 4'b0001;
        tick(12);
        check("rstW_cast_before", 32'(ballots_cast), 1);
        #2 reset = 1'b1;
        #1;
        check("rstW_cast", 32'(ballots_cast), 0);
        check("rstW_candidate", 32'(candidate), 0);
        check("rstW_vote", 32'(vote), 0);
        tick(1);
        reset = 1'b0;
        sb.delete();
        btn = 4'b0;
        tick(12);

        // 300 ballots: the counter saturates at 255.
        v0 = n_vote;
        for (int i = 0; i < 300; i++) begin
            issue();
            sb.push_back(2'(i % 4));
            btn = 4'(1 << (i % 4));
            tick(9);
            btn = 4'b0;
            tick(8);
        end
        check("sat_votes", 32'(n_vote - v0), 300);
        check("sat_cast", 32'(ballots_cast), 255);
        check("sat_last_candidate", 32'(candidate), 3);
        check("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
